// File: rtl/ws2812_cmd_parser.sv
// ws2812_cmd_parser: turns the UART byte stream into per-LED colour writes.
// Packet: 0xAA sync, index, R, G, B, checksum (index^R^G^B).
// An index of 0xFF broadcasts one colour to every LED on the strip.
module ws2812_cmd_parser #(
    parameter int NUM_LEDS = 8,     // LEDs on the strip, 1..255
    parameter int TIMEOUT  = 2400   // max idle cycles between bytes of a packet
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        write,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic        busy
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [7:0]      LEDS     = 8'(NUM_LEDS);
    localparam logic [7:0]      LAST_LED = 8'(NUM_LEDS - 1);
    localparam logic [7:0]      SYNC     = 8'hAA;
    localparam logic [7:0]      BCAST_IX = 8'hFF;

    typedef enum logic [2:0] {IDLE, IDX, RED, GRN, BLU, CHK, BCAST} state_t;

    state_t        state;
    logic [7:0]    idx_q;
    logic [7:0]    red_q;
    logic [7:0]    grn_q;
    logic [7:0]    blu_q;
    logic [7:0]    csum_q;      // running XOR of index, R, G, B
    logic [CW-1:0] to_cnt;      // idle cycles since the last accepted byte
    logic [7:0]    bcast_idx;   // next LED to be written during a broadcast
    logic          ovr_pend;    // overrun seen on the cycle pkt_ok was issued

    // Packet FSM with all outputs registered; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx_q     <= '0;
            red_q     <= '0;
            grn_q     <= '0;
            blu_q     <= '0;
            csum_q    <= '0;
            to_cnt    <= '0;
            bcast_idx <= '0;
            ovr_pend  <= 1'b0;
            rgb_data  <= '0;
            led_num   <= '0;
            write     <= 1'b0;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every comparison below sees the
            // value the register held at the start of this cycle, not one
            // updated earlier in the same block.
            write   <= 1'b0;
            pkt_ok  <= 1'b0;
            pkt_err <= 1'b0;
            busy    <= 1'b0;

            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (rx_valid && rx_data == SYNC) begin
                        csum_q <= '0;
                        state  <= IDX;
                    end
                end

                IDX, RED, GRN, BLU, CHK: begin
                    if (rx_valid) begin
                        // A byte on the cycle the timeout would fire still wins.
                        to_cnt <= '0;
                        csum_q <= csum_q ^ rx_data;
                        case (state)
                            IDX: begin idx_q <= rx_data; state <= RED; end
                            RED: begin red_q <= rx_data; state <= GRN; end
                            GRN: begin grn_q <= rx_data; state <= BLU; end
                            BLU: begin blu_q <= rx_data; state <= CHK; end
                            default: begin
                                if (rx_data != csum_q) begin
                                    pkt_err <= 1'b1;
                                    state   <= IDLE;
                                end else if (idx_q < LEDS) begin
                                    write    <= 1'b1;
                                    led_num  <= idx_q;
                                    rgb_data <= {grn_q, red_q, blu_q};
                                    pkt_ok   <= 1'b1;
                                    state    <= IDLE;
                                end else if (idx_q == BCAST_IX) begin
                                    write     <= 1'b1;
                                    busy      <= 1'b1;
                                    led_num   <= '0;
                                    rgb_data  <= {grn_q, red_q, blu_q};
                                    pkt_ok    <= (NUM_LEDS == 1);
                                    bcast_idx <= 8'd1;
                                    ovr_pend  <= 1'b0;
                                    state     <= BCAST;
                                end else begin
                                    pkt_err <= 1'b1;
                                    state   <= IDLE;
                                end
                            end
                        endcase
                    end else if (to_cnt == TO_LAST) begin
                        pkt_err <= 1'b1;
                        to_cnt  <= '0;
                        state   <= IDLE;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end

                BCAST: begin
                    to_cnt <= '0;
                    if (bcast_idx < LEDS) begin
                        write     <= 1'b1;
                        busy      <= 1'b1;
                        led_num   <= bcast_idx;
                        bcast_idx <= bcast_idx + 8'd1;
                        if (bcast_idx == LAST_LED) begin
                            // pkt_ok owns this cycle; report an overrun one later.
                            pkt_ok   <= 1'b1;
                            ovr_pend <= rx_valid;
                        end else begin
                            pkt_err <= rx_valid;
                        end
                    end else begin
                        pkt_err  <= rx_valid | ovr_pend;
                        ovr_pend <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_cmd_parser.sv
// Self-checking bench for ws2812_cmd_parser: an event-scheduling reference
// model predicts every output for every cycle; directed packets pin the model
// with literal expectations, then randomized traffic exercises the rest.
module tb_ws2812_cmd_parser;

    localparam int NUM_LEDS = 8;
    localparam int TIMEOUT  = 2400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        write;
    logic        pkt_ok;
    logic        pkt_err;
    logic        busy;

    ws2812_cmd_parser #(.NUM_LEDS(NUM_LEDS), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rgb_data (rgb_data),
        .led_num  (led_num),
        .write    (write),
        .pkt_ok   (pkt_ok),
        .pkt_err  (pkt_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    // Expected output events, keyed by the clock edge after which they are visible.
    bit          wr_at[int];
    logic [7:0]  led_at[int];
    logic [23:0] rgb_at[int];
    bit          ok_at[int];
    bit          err_at[int];
    bit          busy_at[int];
    bit          rst_at[int];

    // Observed tallies used by the directed sections.
    int          w_cnt = 0, ok_cnt = 0, err_cnt = 0, busy_cnt = 0;
    logic [7:0]  last_led;
    logic [23:0] last_rgb;
    int          w0, ok0, err0, busy0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_cnt, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    int         m_idle = 0;
    int         m_bstart = -100;
    int         m_bend = -100;

    function automatic void clear_from(input int e);
        for (int k = e; k < e + NUM_LEDS + 4; k++) begin
            wr_at.delete(k); led_at.delete(k); rgb_at.delete(k);
            ok_at.delete(k); err_at.delete(k); busy_at.delete(k);
        end
    endfunction

    function automatic void finish_packet(input int e);
        logic [7:0]  ix, c;
        logic [23:0] col;
        ix  = mq[1];
        c   = mq[5];
        col = {mq[3], mq[2], mq[4]};
        if (c != (mq[1] ^ mq[2] ^ mq[3] ^ mq[4])) begin
            err_at[e] = 1'b1;
        end else if (int'(ix) < NUM_LEDS) begin
            wr_at[e] = 1'b1; led_at[e] = ix; rgb_at[e] = col; ok_at[e] = 1'b1;
        end else if (ix == 8'hFF) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                wr_at[e+i] = 1'b1; led_at[e+i] = 8'(i); rgb_at[e+i] = col; busy_at[e+i] = 1'b1;
            end
            ok_at[e+NUM_LEDS-1] = 1'b1;
            m_bstart = e;
            m_bend   = e + NUM_LEDS;
        end else begin
            err_at[e] = 1'b1;
        end
        mq.delete();
    endfunction

    initial begin
        int e;
        forever begin
            @(posedge clk);
            edge_cnt++;
            e = edge_cnt;
            if (reset) begin
                clear_from(e);
                rst_at[e] = 1'b1;
                mq.delete();
                m_idle = 0;
                m_bend = -100;
            end else if (e > m_bstart && e <= m_bend) begin
                // Broadcast window: bytes are dropped; an error that would land
                // on the pkt_ok cycle is reported one cycle later instead.
                if (rx_valid)
                    err_at[(e == m_bstart + NUM_LEDS - 1) ? e + 1 : e] = 1'b1;
            end else if (mq.size() == 0) begin
                if (rx_valid && rx_data == 8'hAA) begin
                    mq.push_back(rx_data);
                    m_idle = 0;
                end
            end else if (rx_valid) begin
                mq.push_back(rx_data);
                m_idle = 0;
                if (mq.size() == 6) finish_packet(e);
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    err_at[e] = 1'b1;
                    mq.delete();
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        logic [7:0]  hl;
        logic [23:0] hr;
        int k;
        forever begin
            @(negedge clk);
            k = edge_cnt;
            if (k > 0) begin
                if (rst_at.exists(k)) begin hl = '0; hr = '0; end
                if (wr_at.exists(k)) begin hl = led_at[k]; hr = rgb_at[k]; end
                check("write",    32'(write),    32'(wr_at.exists(k)));
                check("pkt_ok",   32'(pkt_ok),   32'(ok_at.exists(k)));
                check("pkt_err",  32'(pkt_err),  32'(err_at.exists(k)));
                check("busy",     32'(busy),     32'(busy_at.exists(k)));
                check("led_num",  32'(led_num),  32'(hl));
                check("rgb_data", 32'(rgb_data), 32'(hr));
                if (write === 1'b1) begin w_cnt++; last_led = led_num; last_rgb = rgb_data; end
                if (pkt_ok === 1'b1)  ok_cnt++;
                if (pkt_err === 1'b1) err_cnt++;
                if (busy === 1'b1)    busy_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_pkt(input logic [7:0] ix, r, g, b, c, input int maxgap);
        logic [7:0] body[5];
        body = '{ix, r, g, b, c};
        send(8'hAA);
        for (int i = 0; i < 5; i++) begin
            idle($urandom_range(0, maxgap));
            send(body[i]);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic snap();
        w0 = w_cnt; ok0 = ok_cnt; err0 = err_cnt; busy0 = busy_cnt;
    endtask

    task automatic expect_counts(input string tag, input int dw, dok, derr, dbusy);
        check({tag, "_writes"}, 32'(w_cnt - w0),       32'(dw));
        check({tag, "_ok"},     32'(ok_cnt - ok0),     32'(dok));
        check({tag, "_err"},    32'(err_cnt - err0),   32'(derr));
        check({tag, "_busy"},   32'(busy_cnt - busy0), 32'(dbusy));
    endtask

    task automatic expect_last(input string tag, input logic [7:0] l, input logic [23:0] c);
        check({tag, "_led"}, 32'(last_led), 32'(l));
        check({tag, "_rgb"}, 32'(last_rgb), 32'(c));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] ix, r, g, b, c, nb;
        int sel;

        idle(3);
        reset = 1'b0;
        check("reset_write",   32'(write),    32'd0);
        check("reset_busy",    32'(busy),     32'd0);
        check("reset_led_num", 32'(led_num),  32'd0);
        check("reset_rgb",     32'(rgb_data), 32'd0);
        idle(2);

        // Good packet.
        snap(); send_pkt(8'h03, 8'h10, 8'h20, 8'h30, 8'h03, 0); idle(4);
        expect_counts("good", 1, 1, 0, 0); expect_last("good", 8'd3, 24'h201030);

        // Bad checksum, then a good packet with gaps between bytes.
        snap(); send_pkt(8'h03, 8'h10, 8'h20, 8'h30, 8'h04, 0); idle(4);
        expect_counts("badsum", 0, 0, 1, 0);
        snap(); send_pkt(8'h05, 8'h11, 8'h22, 8'h44, 8'h72, 3); idle(4);
        expect_counts("after_bad", 1, 1, 0, 0); expect_last("after_bad", 8'd5, 24'h221144);

        // Broadcast with an overrun byte well inside the window.
        snap(); send_pkt(8'hFF, 8'h01, 8'h02, 8'h04, 8'hF8, 0); idle(2); send(8'h55); idle(10);
        expect_counts("bcast", 8, 1, 1, 8); expect_last("bcast", 8'd7, 24'h020104);

        // Broadcast with an overrun byte landing on the pkt_ok cycle's edge.
        snap(); send_pkt(8'hFF, 8'h01, 8'h02, 8'h04, 8'hF8, 0); idle(NUM_LEDS - 2); send(8'h13); idle(6);
        expect_counts("bcast_edge", 8, 1, 1, 8);

        // Out-of-range index; 0xAA inside a packet is data.
        snap(); send_pkt(8'h08, 8'h00, 8'h00, 8'h00, 8'h08, 0); idle(4);
        expect_counts("range", 0, 0, 1, 0);
        snap(); send_pkt(8'h01, 8'hAA, 8'h00, 8'h00, 8'hAB, 0); idle(4);
        expect_counts("resync", 1, 1, 0, 0); expect_last("resync", 8'd1, 24'h00AA00);

        // Timeout fires after TIMEOUT idle cycles.
        snap(); send(8'hAA); send(8'h02); send(8'h10); idle(TIMEOUT + 3);
        expect_counts("timeout", 0, 0, 1, 0);
        snap(); send_pkt(8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 0); idle(4);
        expect_counts("post_timeout", 1, 1, 0, 0); expect_last("post_timeout", 8'd4, 24'h020103);

        // A byte on the firing cycle is accepted instead.
        snap(); send(8'hAA); send(8'h02); send(8'h10); idle(TIMEOUT - 1);
        send(8'h20); send(8'h30); send(8'h02); idle(4);
        expect_counts("timeout_edge", 1, 1, 0, 0); expect_last("timeout_edge", 8'd2, 24'h201030);

        // Reset while LED 3 of a broadcast is being written.
        snap(); send_pkt(8'hFF, 8'h01, 8'h02, 8'h04, 8'hF8, 0); idle(3);
        check("mid_bcast_write", 32'(write),   32'd1);
        check("mid_bcast_led",   32'(led_num), 32'd3);
        do_reset();
        check("rst_bcast_write", 32'(write),    32'd0);
        check("rst_bcast_busy",  32'(busy),     32'd0);
        check("rst_bcast_led",   32'(led_num),  32'd0);
        check("rst_bcast_rgb",   32'(rgb_data), 32'd0);
        check("rst_bcast_ok",    32'(pkt_ok),   32'd0);
        idle(12);
        expect_counts("rst_bcast", 4, 0, 0, 4);
        snap(); send_pkt(8'h06, 8'h0F, 8'hF0, 8'h33, 8'h06 ^ 8'h0F ^ 8'hF0 ^ 8'h33, 1); idle(4);
        expect_counts("post_reset", 1, 1, 0, 0); expect_last("post_reset", 8'd6, 24'hF00F33);

        // Randomized traffic, all checked by the model.
        for (int it = 0; it < 300; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)      ix = 8'($urandom_range(0, NUM_LEDS - 1));
            else if (sel < 7) ix = 8'hFF;
            else              ix = 8'($urandom_range(NUM_LEDS, 254));
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            c = ix ^ r ^ g ^ b;
            if ($urandom_range(0, 4) == 0) c = c ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) begin
                nb = 8'($urandom);
                if (nb == 8'hAA) nb = 8'h55;
                send(nb);
            end
            if ($urandom_range(0, 19) == 0) begin
                send(8'hAA); send(ix); idle($urandom_range(0, 2));
                do_reset();
            end else begin
                send_pkt(ix, r, g, b, c, 2);
                if (ix == 8'hFF && $urandom_range(0, 1) == 1) begin
                    idle($urandom_range(0, NUM_LEDS));
                    send(8'($urandom));
                end
            end
            idle($urandom_range(0, NUM_LEDS + 2));
        end

        // One more timeout from a random partial packet.
        send(8'hAA);
        for (int i = 0; i < $urandom_range(0, 4); i++) send(8'($urandom));
        idle(TIMEOUT + 4);
        idle(NUM_LEDS + 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
